adc_scan_controller: RTL
========================

Name: adc_scan_controller

Overview:
- Sequences the 8-channel serial ADC (ADC128S022-style interface: CS_N, SCLK, DIN, DOUT) from the 50 MHz system clock.
- Generates a 3.125 MHz SCLK using an internal clock-enable divider. No derived clock is used.
- Scans the channels enabled in a mask in round-robin order and emits one tagged 12-bit sample per frame.
- The results feed the line-sensor algorithm and the CPU.

Parameters:
- DIV_HALF, 8, clk_50M cycles per SCLK half-period (8 gives 3.125 MHz); legal range 2..255.
- CH_W, 3, channel address width.

Ports:
- clk_50M  input  1  50 MHz system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = keep scanning; 0 = stop after the current frame.
- ch_mask  input  8  channel enable mask; bit i = scan channel i.
- adc_dout  input  1  ADC serial data out.
- adc_cs_n  output  1  ADC chip select, active low.
- adc_sck  output  1  ADC serial clock; idles high.
- adc_din  output  1  ADC serial data in (address bits).
- data_valid  output  1  one-cycle pulse; data and data_ch are valid in that cycle.
- data  output  12  converted sample, held until the next pulse.
- data_ch  output  3  channel that data belongs to.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: adc_cs_n=1, adc_sck=1, adc_din=0, data_valid=0, data=0, data_ch=0, busy=0. FSM=IDLE, cur_ch=0, conv_ch=0.
- Reset is synchronous and dominates everything. A reset mid-frame forces cs_n=1 and sck=1 on the next edge, with no data_valid.
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE: if enable=1 and ch_mask!=0:
  - latch ch_mask into mask_q;
  - cur_ch = lowest set bit of mask_q;
  - go to SETUP.
- SETUP: cs_n=0, sck=1 for DIV_HALF cycles, then go to SHIFT with bit index k=0.
- SHIFT: 16 SCLK periods, k=0..15.
  - Each period: sck=0 for DIV_HALF cycles, then sck=1 for DIV_HALF cycles.
  - adc_din changes only on sck falling transitions. It carries cur_ch[2], cur_ch[1], cur_ch[0] during periods k=2,3,4 (MSB first), and 0 otherwise.
  - adc_dout is sampled in the last low-phase cycle of each period (coincident with sck rising) for k=4..15, shifting MSB first into a 12-bit register.
  - After the high phase of k=15, go to GAP.
- GAP entry cycle:
  - data_valid=1 for exactly this cycle;
  - data = shift register; data_ch = conv_ch;
  - conv_ch = cur_ch (ADC pipelining: each frame returns the channel addressed in the previous frame; the first frame after IDLE reports channel 0);
  - cur_ch = next set bit of mask_q above cur_ch, wrapping to the lowest set bit.
- GAP: cs_n=1, sck=1 for DIV_HALF cycles.
  - At the end, if enable=1 and ch_mask!=0: re-latch mask_q. If cur_ch is not set in the new mask, replace it with the next set bit at or after cur_ch (wrapping). Go to SETUP.
  - Otherwise go to IDLE.
- Frame length: 34*DIV_HALF cycles (272 at the default). Back-to-back frames are gapless beyond GAP.
- enable or ch_mask changes mid-frame have no effect until the end of GAP. A frame in progress always completes.
- Single-bit mask: the same channel is addressed every frame.
- busy=1 in SETUP, SHIFT and GAP.
- Counters:
  - half-period counter width = ceil(log2(DIV_HALF)); wraps to 0 at DIV_HALF-1;
  - bit counter 4 bits; wraps to 0 only on exit from SHIFT.

Test Plan:
- Reset mid-SHIFT (assert reset at cycle 100 of a frame) -> next edge cs_n=1, sck=1, busy=0, no data_valid. After release with enable=1, the frame restarts from SETUP.
- enable=1, ch_mask=8'h01, ADC model returns 12'hA5C -> cs_n low for 264 cycles, 16 sck periods of 16 cycles each. The first data_valid arrives 264 cycles after cs_n falls, with data=12'hA5C and data_ch=0. The repetition period is 272 cycles.
- ch_mask=8'b1010_0100 with the ADC model returning 12'h100+channel for the previously addressed channel -> din address sequence 2,5,7,2,... Reported (data_ch, data) sequence is (0,100), (2,102), (5,105), (7,107).
- Drop enable at mid-SHIFT of frame 2 -> frame 2 completes with data_valid, then IDLE with cs_n=1, sck=1, busy=0, and no further frames.
- ch_mask=0 with enable=1 -> remains in IDLE and busy=0. Setting ch_mask=8'h80 starts a frame with din address 3'b111.
- Change ch_mask from 8'h06 to 8'h09 while channel 2 is addressed -> the next frame addresses channel 3, then channel 0. data_ch still reports the previously addressed channel.

Source files
------------

// File: rtl/adc_scan_controller_if.sv
// Control, ADC pin and tagged-sample signals of the ADC scan controller.
// The controller side uses the master modport; the ADC/consumer side uses slave.
interface adc_scan_controller_if #(
    parameter int CH_W = 3
);
    logic                 enable;
    logic [(1<<CH_W)-1:0] ch_mask;
    logic                 adc_dout;
    logic                 adc_cs_n;
    logic                 adc_sck;
    logic                 adc_din;
    logic                 data_valid;
    logic [11:0]          data;
    logic [CH_W-1:0]      data_ch;
    logic                 busy;

    modport master (
        input  enable, ch_mask, adc_dout,
        output adc_cs_n, adc_sck, adc_din, data_valid, data, data_ch, busy
    );

    modport slave (
        output enable, ch_mask, adc_dout,
        input  adc_cs_n, adc_sck, adc_din, data_valid, data, data_ch, busy
    );
endinterface

// File: rtl/adc_scan_controller.sv
// Round-robin scan sequencer for an 8-channel ADC128S022-style serial ADC.
// SCLK is a registered output paced by a clock-enable divider off clk_50M.
module adc_scan_controller #(
    parameter int DIV_HALF = 8,
    parameter int CH_W     = 3
) (
    input  logic                  clk_50M,
    input  logic                  reset,
    adc_scan_controller_if.master bus
);
    localparam int NCH  = 1 << CH_W;
    localparam int HC_W = $clog2(DIV_HALF);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(DIV_HALF - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t          state;
    logic [HC_W-1:0] hc;
    logic [3:0]      k;
    logic [NCH-1:0]  mask_q;
    logic [CH_W-1:0] cur_ch;
    logic [CH_W-1:0] conv_ch;
    logic [11:0]     sample_sr;
    logic            cs_n_r;
    logic            sck_r;
    logic            din_r;
    logic            valid_r;
    logic            busy_r;
    logic [11:0]     data_r;
    logic [CH_W-1:0] data_ch_r;
    logic            hc_end;
    logic            sample_en;

    // First set bit of mask at or after start, wrapping; start itself if mask is empty.
    function automatic logic [CH_W-1:0] next_set(input logic [NCH-1:0] mask,
                                                 input logic [CH_W-1:0] start);
        logic [CH_W-1:0] pick;
        logic [CH_W-1:0] c;
        pick = start;
        for (int i = NCH - 1; i >= 0; i--) begin
            c = start + CH_W'(i);
            if (mask[c]) pick = c;
        end
        return pick;
    endfunction

    // Address bit driven during SCLK period kk: channel MSB first in periods 2..CH_W+1.
    function automatic logic addr_bit(input logic [3:0] kk, input logic [CH_W-1:0] ch);
        logic [CH_W-1:0] s;
        s = ch >> (4'(CH_W + 1) - kk);
        return (kk >= 4'd2 && kk <= 4'(CH_W + 1)) ? s[0] : 1'b0;
    endfunction

    assign hc_end    = (hc == HC_LAST);
    assign sample_en = (state == SHIFT) && !sck_r && hc_end && (k >= 4'd4);

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state     <= IDLE;
            hc        <= '0;
            k         <= '0;
            mask_q    <= '0;
            cur_ch    <= '0;
            conv_ch   <= '0;
            cs_n_r    <= 1'b1;
            sck_r     <= 1'b1;
            din_r     <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            data_r    <= '0;
            data_ch_r <= '0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    hc <= '0;
                    if (bus.enable && |bus.ch_mask) begin
                        mask_q  <= bus.ch_mask;
                        cur_ch  <= next_set(bus.ch_mask, CH_W'(0));
                        conv_ch <= '0;
                        cs_n_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (hc_end) begin
                        hc    <= '0;
                        k     <= '0;
                        sck_r <= 1'b0;
                        din_r <= addr_bit(4'd0, cur_ch);
                        state <= SHIFT;
                    end else begin
                        hc <= hc + HC_W'(1);
                    end
                end
                SHIFT: begin
                    if (!hc_end) begin
                        hc <= hc + HC_W'(1);
                    end else begin
                        hc <= '0;
                        if (!sck_r) begin
                            sck_r <= 1'b1;
                        end else if (k == 4'd15) begin
                            // ADC pipelining: this frame's result belongs to the previously addressed channel.
                            k         <= '0;
                            cs_n_r    <= 1'b1;
                            din_r     <= 1'b0;
                            valid_r   <= 1'b1;
                            data_r    <= sample_sr;
                            data_ch_r <= conv_ch;
                            conv_ch   <= cur_ch;
                            cur_ch    <= next_set(mask_q, cur_ch + CH_W'(1));
                            state     <= GAP;
                        end else begin
                            k     <= k + 4'd1;
                            sck_r <= 1'b0;
                            din_r <= addr_bit(k + 4'd1, cur_ch);
                        end
                    end
                end
                GAP: begin
                    if (!hc_end) begin
                        hc <= hc + HC_W'(1);
                    end else begin
                        hc <= '0;
                        if (bus.enable && |bus.ch_mask) begin
                            mask_q <= bus.ch_mask;
                            cur_ch <= next_set(bus.ch_mask, cur_ch);
                            cs_n_r <= 1'b0;
                            state  <= SETUP;
                        end else begin
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (sample_en) sample_sr <= {sample_sr[10:0], bus.adc_dout};
    end

    assign bus.adc_cs_n   = cs_n_r;
    assign bus.adc_sck    = sck_r;
    assign bus.adc_din    = din_r;
    assign bus.data_valid = valid_r;
    assign bus.data       = data_r;
    assign bus.data_ch    = data_ch_r;
    assign bus.busy       = busy_r;
endmodule
